ntt_ctrl: RTL and testbench
===========================

# ntt_ctrl

In-place NTT sequencer for one 256-coefficient Kyber polynomial stored in the true dual-port coefficient RAM. It generates Cooley-Tukey butterfly read addresses for all 7 layers, tags each coefficient pair with its zeta index for the external butterfly datapath, and writes the results back to the same addresses after a fixed butterfly latency. The block owns both RAM ports for the whole operation. It sits between the polynomial RAM and the butterfly unit, and the top-level FSM starts it.

## Interface
- DEPTH, 8: RAM address width; 256 coefficients.
- BF_LAT, 2: butterfly pipeline latency in cycles, from bf_valid to result on the RAM din ports. Must be even and ≥0; any other value is an elaboration error.
- clk  in  1  clock. One clock domain.
- rst  in  1  reset. Synchronous, active-high.
- start  in  1  begin NTT. Sampled only in IDLE.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- ram_addr_1  out  DEPTH  port-1 address: coefficient a = j.
- ram_addr_2  out  DEPTH  port-2 address: coefficient b = j+len.
- ram_we_1, ram_we_2  out  1  write enables. Always equal.
- bf_valid  out  1  RAM dout_1/dout_2 carry a valid (a,b) pair this cycle.
- bf_zeta_idx  out  7  zeta table index k, aligned with bf_valid.

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: when start=1, go to ISSUE. Clear the layer counter to 0, set k=1, and clear phase.
- ISSUE:
  - phase toggles every cycle. phase 0 is a read issue; phase 1 is a write slot.
  - A read issue drives addr_1=j and addr_2=j+len with we=0, then advances the counters.
  - len = 128>>layer, for layers 0..6.
  - Per layer, group start runs from 0 in steps of 2·len. Within a group, j runs from start to start+len−1.
  - k increments after each group, so it runs 1..127 over the whole NTT.
  - Each layer has 128 butterflies.
  - After the last issue of a layer, go to DRAIN.
- Write-back:
  - Each issue pushes {a, b, k, valid} into a (1+BF_LAT)-deep shift register.
  - When the tail entry is valid, drive the stored addresses with we_1=we_2=1.
  - Because BF_LAT is even, write-back always lands on a phase-1 cycle, so a read and a write never contend for a port.
- Outside ISSUE and write-back cycles, addresses are 0 and we=0.
- DRAIN:
  - Wait until the last write of the layer has been performed (BF_LAT+1 cycles after the last issue).
  - Then either return to ISSUE at phase 0 for layer+1, or, after layer 6, go to DONE.
  - This ordering guarantees no read-after-write hazard across layers.
- DONE: pulse done for 1 cycle, then go to IDLE.
- busy is high in ISSUE and DRAIN, and low in IDLE and DONE.
- start is ignored while busy or in DONE.
- bf_valid and bf_zeta_idx are registered one cycle after the read issue, matching the 1-cycle RAM read latency.
- rst in any state:
  - Next state is IDLE.
  - The shift register is cleared, so no pending write is ever performed.
  - All outputs go to 0.
  - RAM contents are then undefined from the NTT's point of view.

## Timing
- Reset value of all outputs: 0.
- Timing is relative to c0, the cycle in which start is sampled in IDLE.
  - First read issue: c0+1.
  - Read issues within a layer fall on layer_start+0, +2, …, +254.
  - Next layer starts at layer_start + 256 + BF_LAT.
  - bf_valid: issue+1. Write-back: issue+1+BF_LAT.
  - Final write: c0+1+6·(256+BF_LAT)+255+BF_LAT.
  - done: final write +1.
- With BF_LAT=2:
  - Final write at c0+1806, done at c0+1807.
  - busy is high c0+1..c0+1806.
- Throughput: 1 butterfly per 2 cycles.

## Structure
- kyber_pkg (shared package) holds:
  - N=256, NTT_LAYERS=7, ZETA_W=7.
  - The state enum type for ntt_ctrl.
- One sub-module, ntt_addr_gen, holds:
  - The layer, group-start, j and k counters.
  - Outputs a, b, k, last_in_layer and last_layer.
  - Advances on an input step pulse and is cleared by rst or load.
- ntt_ctrl holds the FSM, the phase bit, the write-back shift register and the port muxing.

## Test plan
- Reset, then start at c0:
  - c0+1: addr_1=0, addr_2=128, we=0.
  - c0+2: bf_valid=1, zeta_idx=1.
  - c0+4: we_1=we_2=1 at addresses 0/128.
- Layer 1:
  - First issue at c0+259 reads (0,64) with k=2.
  - Its 65th butterfly reads (128,192) with k=3.
- Layer 6: last issue reads (253,255) with k=127, at c0+1803.
- Port discipline over a full run:
  - No cycle has a read issue and we=1 together.
  - Every address is written exactly 7 times.
  - A RAM loaded with a known polynomial, plus a butterfly reference model, matches the golden NTT output.
- Completion:
  - done is high only at c0+1807; busy falls the same cycle.
  - A start pulse at c0+500 has no effect.
  - A second start after done repeats the identical sequence.
- Reset mid-operation:
  - rst at c0+900 (layer 3, pending writes): next cycle all outputs are 0, and no we is asserted afterwards.
  - A later start completes in exactly 1807 cycles.

Source files
------------

// File: rtl/kyber_pkg.sv
// ---------------------------------------------------------------------------
// kyber_pkg
// Shared constants and types for the Kyber polynomial datapath.
//   N          : coefficients per polynomial
//   NTT_LAYERS : Cooley-Tukey layers in the forward NTT (len 128 .. 2)
//   ZETA_W     : width of the zeta table index k (1..127)
//   ntt_state_t: sequencer states of ntt_ctrl
// ---------------------------------------------------------------------------
package kyber_pkg;

   localparam int N          = 256;
   localparam int NTT_LAYERS = 7;
   localparam int ZETA_W     = 7;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } ntt_state_t;

endpackage

// File: rtl/ntt_addr_gen.sv
// ---------------------------------------------------------------------------
// ntt_addr_gen
// Butterfly address / zeta index generator for an in-place Cooley-Tukey NTT.
// Walks layer -> group -> j, producing one (a, b, k) triple per step.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   load           : restart the walk at layer 0, j 0, k 1
//   step           : advance to the next butterfly
//   a, b           : coefficient addresses j and j+len
//   k              : zeta index of the current group
//   last_in_layer  : current butterfly is the final one of its layer
//   last_layer     : current layer is the final layer (len = 2)
// ---------------------------------------------------------------------------
module ntt_addr_gen
   import kyber_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              step,
   output logic [DEPTH-1:0]  a,
   output logic [DEPTH-1:0]  b,
   output logic [ZETA_W-1:0] k,
   output logic              last_in_layer,
   output logic              last_layer
);

   // One extra bit so that group_start + 2*len can reach N without wrapping.
   localparam logic [DEPTH:0] HALF  = (DEPTH+1)'(N / 2);
   localparam logic [DEPTH:0] TOTAL = (DEPTH+1)'(N);
   localparam logic [DEPTH:0] ONE   = (DEPTH+1)'(1);

   logic [2:0]        layer_reg;
   logic [DEPTH-1:0]  grp_reg;
   logic [DEPTH-1:0]  j_reg;
   logic [ZETA_W-1:0] k_reg;

   logic [DEPTH:0]    len;
   logic [DEPTH:0]    next_grp;
   logic              last_in_group;

   assign len           = HALF >> layer_reg;
   assign next_grp      = {1'b0, grp_reg} + (len << 1);
   assign last_in_group = (({1'b0, j_reg} + ONE) == ({1'b0, grp_reg} + len));
   assign last_in_layer = last_in_group && (next_grp == TOTAL);
   assign last_layer    = (layer_reg == 3'(NTT_LAYERS - 1));

   assign a = j_reg;
   assign b = j_reg + len[DEPTH-1:0];
   assign k = k_reg;

   always_ff @(posedge clk) begin
      if (rst || load) begin
         layer_reg <= '0;
         grp_reg   <= '0;
         j_reg     <= '0;
         k_reg     <= ZETA_W'(1);
      end else if (step) begin
         if (last_in_group) begin
            // k belongs to a group, so it moves on only at group boundaries.
            k_reg <= k_reg + 1'b1;
            if (next_grp == TOTAL) begin
               layer_reg <= layer_reg + 3'd1;
               grp_reg   <= '0;
               j_reg     <= '0;
            end else begin
               grp_reg <= next_grp[DEPTH-1:0];
               j_reg   <= next_grp[DEPTH-1:0];
            end
         end else begin
            j_reg <= j_reg + 1'b1;
         end
      end
   end

endmodule

// File: rtl/ntt_ctrl.sv
// ---------------------------------------------------------------------------
// ntt_ctrl
// In-place NTT sequencer for one 256-coefficient polynomial held in a true
// dual-port RAM. Issues butterfly reads on even cycles, tags each pair with
// its zeta index for the external butterfly unit, and writes the results back
// to the same addresses BF_LAT+1 cycles after the read, always on odd cycles.
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   start                  : begin an NTT (sampled in IDLE only)
//   busy                   : high while reading/draining (ISSUE, DRAIN)
//   done                   : one-cycle completion pulse
//   ram_addr_1, ram_addr_2 : port addresses (a = j, b = j+len)
//   ram_we_1, ram_we_2     : write enables (always equal)
//   bf_valid               : RAM read data carries a valid (a,b) pair
//   bf_zeta_idx            : zeta index aligned with bf_valid
// ---------------------------------------------------------------------------
module ntt_ctrl
   import kyber_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int BF_LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [DEPTH-1:0]  ram_addr_1,
   output logic [DEPTH-1:0]  ram_addr_2,
   output logic              ram_we_1,
   output logic              ram_we_2,
   output logic              bf_valid,
   output logic [ZETA_W-1:0] bf_zeta_idx
);

   // An odd latency would land write-backs on read-issue cycles.
   generate
      if ((BF_LAT < 0) || ((BF_LAT % 2) != 0)) begin : g_bad_lat
         $error("ntt_ctrl: BF_LAT must be even and non-negative");
      end
   endgenerate

   localparam int CNT_W = $clog2(BF_LAT + 2);

   ntt_state_t        state_reg;
   logic              phase_reg;
   logic [CNT_W-1:0]  drain_cnt_reg;
   logic              final_reg;

   logic [DEPTH-1:0]  gen_a;
   logic [DEPTH-1:0]  gen_b;
   logic [ZETA_W-1:0] gen_k;
   logic              gen_last_in_layer;
   logic              gen_last_layer;

   logic              load;
   logic              issue;

   // Write-back pipeline: stage 0 lines up with RAM read data, the tail
   // stage lines up with butterfly results on the RAM din ports.
   logic [DEPTH-1:0]  wb_a_reg [0:BF_LAT];
   logic [DEPTH-1:0]  wb_b_reg [0:BF_LAT];
   logic [ZETA_W-1:0] wb_k_reg [0:BF_LAT];
   logic              wb_v_reg [0:BF_LAT];

   assign load  = (state_reg == S_IDLE) && start;
   assign issue = (state_reg == S_ISSUE) && !phase_reg;

   ntt_addr_gen #(
      .DEPTH(DEPTH)
   ) u_addr_gen (
      .clk          (clk),
      .rst          (rst),
      .load         (load),
      .step         (issue),
      .a            (gen_a),
      .b            (gen_b),
      .k            (gen_k),
      .last_in_layer(gen_last_in_layer),
      .last_layer   (gen_last_layer)
   );

   // Sequencer.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= S_IDLE;
         phase_reg     <= 1'b0;
         drain_cnt_reg <= '0;
         final_reg     <= 1'b0;
      end else begin
         unique case (state_reg)
            S_IDLE: begin
               if (start) begin
                  state_reg <= S_ISSUE;
                  phase_reg <= 1'b0;
                  final_reg <= 1'b0;
               end
            end
            S_ISSUE: begin
               phase_reg <= ~phase_reg;
               if (!phase_reg && gen_last_in_layer) begin
                  // Wait for the last write of this layer before the next
                  // layer reads anything it may depend on.
                  state_reg     <= S_DRAIN;
                  drain_cnt_reg <= CNT_W'(BF_LAT);
                  final_reg     <= gen_last_layer;
               end
            end
            S_DRAIN: begin
               if (drain_cnt_reg == '0) begin
                  phase_reg <= 1'b0;
                  state_reg <= final_reg ? S_DONE : S_ISSUE;
               end else begin
                  drain_cnt_reg <= drain_cnt_reg - 1'b1;
               end
            end
            S_DONE: begin
               state_reg <= S_IDLE;
            end
            default: begin
               state_reg <= S_IDLE;
            end
         endcase
      end
   end

   // Write-back shift register; reset drops every pending write.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i <= BF_LAT; i++) begin
            wb_v_reg[i] <= 1'b0;
            wb_a_reg[i] <= '0;
            wb_b_reg[i] <= '0;
            wb_k_reg[i] <= '0;
         end
      end else begin
         wb_v_reg[0] <= issue;
         wb_a_reg[0] <= issue ? gen_a : '0;
         wb_b_reg[0] <= issue ? gen_b : '0;
         wb_k_reg[0] <= issue ? gen_k : '0;
         for (int i = 1; i <= BF_LAT; i++) begin
            wb_v_reg[i] <= wb_v_reg[i-1];
            wb_a_reg[i] <= wb_a_reg[i-1];
            wb_b_reg[i] <= wb_b_reg[i-1];
            wb_k_reg[i] <= wb_k_reg[i-1];
         end
      end
   end

   // Port muxing: read addresses on issue cycles, stored addresses on
   // write-back cycles, zero otherwise. The two never coincide.
   always_comb begin
      ram_addr_1 = '0;
      ram_addr_2 = '0;
      if (issue) begin
         ram_addr_1 = gen_a;
         ram_addr_2 = gen_b;
      end else if (wb_v_reg[BF_LAT]) begin
         ram_addr_1 = wb_a_reg[BF_LAT];
         ram_addr_2 = wb_b_reg[BF_LAT];
      end
   end

   assign ram_we_1    = wb_v_reg[BF_LAT];
   assign ram_we_2    = wb_v_reg[BF_LAT];
   assign bf_valid    = wb_v_reg[0];
   assign bf_zeta_idx = wb_k_reg[0];
   assign busy        = (state_reg == S_ISSUE) || (state_reg == S_DRAIN);
   assign done        = (state_reg == S_DONE);

endmodule

// File: tb/tb_ntt_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ntt_ctrl
// Directed bench for ntt_ctrl with a dual-port RAM model (registered read),
// a modular butterfly model of latency BF_LAT, and a reference NTT.
// ---------------------------------------------------------------------------
module tb_ntt_ctrl;

   localparam int BF_LAT = 2;
   localparam int Q      = 3329;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       busy;
   logic       done;
   logic [7:0] ram_addr_1;
   logic [7:0] ram_addr_2;
   logic       ram_we_1;
   logic       ram_we_2;
   logic       bf_valid;
   logic [6:0] bf_zeta_idx;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ntt_ctrl #(
      .DEPTH (8),
      .BF_LAT(BF_LAT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .busy       (busy),
      .done       (done),
      .ram_addr_1 (ram_addr_1),
      .ram_addr_2 (ram_addr_2),
      .ram_we_1   (ram_we_1),
      .ram_we_2   (ram_we_2),
      .bf_valid   (bf_valid),
      .bf_zeta_idx(bf_zeta_idx)
   );

   // ---------------- RAM + butterfly models ----------------
   int         zeta_tab [128];
   int         init_poly[256];
   int         golden   [256];
   logic [11:0] mem     [256];
   logic [11:0] dout_1, dout_2;
   logic [11:0] pipe_1 [BF_LAT];
   logic [11:0] pipe_2 [BF_LAT];
   logic        ram_load = 1'b0;

   function automatic logic [11:0] bf_sum(input logic [11:0] a, input logic [11:0] b,
                                          input logic [6:0] k);
      int t;
      t = (zeta_tab[k] * int'(b)) % Q;
      return 12'((int'(a) + t) % Q);
   endfunction

   function automatic logic [11:0] bf_diff(input logic [11:0] a, input logic [11:0] b,
                                           input logic [6:0] k);
      int t;
      t = (zeta_tab[k] * int'(b)) % Q;
      return 12'((int'(a) - t + Q) % Q);
   endfunction

   always @(posedge clk) begin
      if (ram_load) begin
         for (int i = 0; i < 256; i++) mem[i] <= 12'(init_poly[i]);
      end else begin
         if (ram_we_1) mem[ram_addr_1] <= pipe_1[BF_LAT-1];
         if (ram_we_2) mem[ram_addr_2] <= pipe_2[BF_LAT-1];
      end
      dout_1 <= mem[ram_addr_1];
      dout_2 <= mem[ram_addr_2];
      pipe_1[0] <= bf_sum(dout_1, dout_2, bf_zeta_idx);
      pipe_2[0] <= bf_diff(dout_1, dout_2, bf_zeta_idx);
      for (int i = 1; i < BF_LAT; i++) begin
         pipe_1[i] <= pipe_1[i-1];
         pipe_2[i] <= pipe_2[i-1];
      end
   end

   task automatic ntt_golden();
      int k;
      int zeta;
      int t;
      k = 1;
      for (int i = 0; i < 256; i++) golden[i] = init_poly[i];
      for (int len = 128; len >= 2; len = len / 2) begin
         for (int s = 0; s < 256; s = s + 2 * len) begin
            zeta = zeta_tab[k];
            k++;
            for (int j = s; j < s + len; j++) begin
               t = (zeta * golden[j + len]) % Q;
               golden[j + len] = (golden[j] - t + Q) % Q;
               golden[j]       = (golden[j] + t) % Q;
            end
         end
      end
   endtask

   task automatic load_ram();
      @(negedge clk);
      ram_load = 1'b1;
      @(negedge clk);
      ram_load = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst   = 1'b1;
      start = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, done, ram_we_1, ram_we_2, bf_valid} !== 5'b0) begin
         errors++;
         $display("FAIL reset_flags got busy=%b done=%b we=%b%b valid=%b want 0",
                  busy, done, ram_we_1, ram_we_2, bf_valid);
      end
      checks++;
      if ({ram_addr_1, ram_addr_2, bf_zeta_idx} !== 23'd0) begin
         errors++;
         $display("FAIL reset_buses got a1=%0d a2=%0d k=%0d want 0",
                  ram_addr_1, ram_addr_2, bf_zeta_idx);
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_no_start got busy=%b want 0", busy);
      end
      $display("test_reset done");
   endtask

   // Full NTT run; sig is a per-cycle fingerprint of every DUT output.
   task automatic run_op(input string tag, input bit poke, output logic [63:0] sig);
      int   wr_cnt[256];
      int   coll, we_diff, busy_bad, done_cnt, done_at, bad_addr, bad_data;
      logic prev_we;
      bit   exp_busy;

      foreach (wr_cnt[i]) wr_cnt[i] = 0;
      coll = 0; we_diff = 0; busy_bad = 0; done_cnt = 0; done_at = -1;
      bad_addr = 0; bad_data = 0; prev_we = 1'b0; sig = '0;
      ntt_golden();
      load_ram();

      @(negedge clk);
      start = 1'b1;                  // cycle c0
      @(negedge clk);
      start = 1'b0;
      for (int rel = 1; rel <= 1812; rel++) begin
         sig = {sig[58:0], sig[63:59]} ^ 64'({ram_addr_1, ram_addr_2, ram_we_1, ram_we_2,
                                             bf_valid, bf_zeta_idx, busy, done});
         case (rel)
            1: begin
               checks++;
               if (ram_addr_1 !== 8'd0 || ram_addr_2 !== 8'd128) begin
                  errors++;
                  $display("FAIL %s first_issue_addr got %0d/%0d want 0/128", tag, ram_addr_1, ram_addr_2);
               end
               checks++;
               if (ram_we_1 !== 1'b0 || busy !== 1'b1) begin
                  errors++;
                  $display("FAIL %s first_issue_ctl got we=%b busy=%b want 0/1", tag, ram_we_1, busy);
               end
            end
            2: begin
               checks++;
               if (bf_valid !== 1'b1 || bf_zeta_idx !== 7'd1) begin
                  errors++;
                  $display("FAIL %s first_valid got v=%b k=%0d want 1/1", tag, bf_valid, bf_zeta_idx);
               end
            end
            4: begin
               checks++;
               if (ram_we_1 !== 1'b1 || ram_we_2 !== 1'b1 || ram_addr_1 !== 8'd0 || ram_addr_2 !== 8'd128) begin
                  errors++;
                  $display("FAIL %s first_write got we=%b%b a=%0d/%0d want 11 0/128",
                           tag, ram_we_1, ram_we_2, ram_addr_1, ram_addr_2);
               end
            end
            259: begin
               checks++;
               if (ram_addr_1 !== 8'd0 || ram_addr_2 !== 8'd64 || ram_we_1 !== 1'b0) begin
                  errors++;
                  $display("FAIL %s layer1_first got %0d/%0d we=%b want 0/64 we=0", tag, ram_addr_1, ram_addr_2, ram_we_1);
               end
            end
            260: begin
               checks++;
               if (bf_valid !== 1'b1 || bf_zeta_idx !== 7'd2) begin
                  errors++;
                  $display("FAIL %s layer1_k got v=%b k=%0d want 1/2", tag, bf_valid, bf_zeta_idx);
               end
            end
            387: begin
               checks++;
               if (ram_addr_1 !== 8'd128 || ram_addr_2 !== 8'd192) begin
                  errors++;
                  $display("FAIL %s layer1_bf65 got %0d/%0d want 128/192", tag, ram_addr_1, ram_addr_2);
               end
            end
            388: begin
               checks++;
               if (bf_zeta_idx !== 7'd3) begin
                  errors++;
                  $display("FAIL %s layer1_bf65_k got %0d want 3", tag, bf_zeta_idx);
               end
            end
            1803: begin
               checks++;
               if (ram_addr_1 !== 8'd253 || ram_addr_2 !== 8'd255 || ram_we_1 !== 1'b0) begin
                  errors++;
                  $display("FAIL %s last_issue got %0d/%0d we=%b want 253/255 we=0", tag, ram_addr_1, ram_addr_2, ram_we_1);
               end
            end
            1804: begin
               checks++;
               if (bf_valid !== 1'b1 || bf_zeta_idx !== 7'd127) begin
                  errors++;
                  $display("FAIL %s last_k got v=%b k=%0d want 1/127", tag, bf_valid, bf_zeta_idx);
               end
            end
            1806: begin
               checks++;
               if (ram_we_1 !== 1'b1 || ram_addr_1 !== 8'd253 || ram_addr_2 !== 8'd255) begin
                  errors++;
                  $display("FAIL %s final_write got we=%b a=%0d/%0d want 1 253/255", tag, ram_we_1, ram_addr_1, ram_addr_2);
               end
            end
            default: ;
         endcase

         if (ram_we_1 !== ram_we_2) we_diff++;
         if (ram_we_1 === 1'b1) begin
            wr_cnt[ram_addr_1]++;
            wr_cnt[ram_addr_2]++;
         end
         // bf_valid now means a read was issued last cycle.
         if (bf_valid === 1'b1 && prev_we === 1'b1) coll++;
         prev_we = ram_we_1;
         exp_busy = (rel <= 1806);
         if (busy !== exp_busy) busy_bad++;
         if (done === 1'b1) begin
            done_cnt++;
            done_at = rel;
         end

         start = (poke && rel == 500);
         @(negedge clk);
      end
      start = 1'b0;

      foreach (wr_cnt[i]) if (wr_cnt[i] != 7) bad_addr++;
      for (int i = 0; i < 256; i++) if (int'(mem[i]) != golden[i]) bad_data++;

      checks++;
      if (done_cnt != 1 || done_at != 1807) begin
         errors++;
         $display("FAIL %s done_timing got count=%0d at=%0d want 1 at 1807", tag, done_cnt, done_at);
      end
      checks++;
      if (busy_bad != 0) begin
         errors++;
         $display("FAIL %s busy_window got %0d bad cycles want 0", tag, busy_bad);
      end
      checks++;
      if (coll != 0 || we_diff != 0) begin
         errors++;
         $display("FAIL %s port_discipline got coll=%0d we_diff=%0d want 0/0", tag, coll, we_diff);
      end
      checks++;
      if (bad_addr != 0) begin
         errors++;
         $display("FAIL %s write_count got %0d addresses not written 7 times want 0", tag, bad_addr);
      end
      checks++;
      if (bad_data != 0) begin
         errors++;
         $display("FAIL %s ntt_result got %0d wrong coefficients (mem[0]=%0d golden=%0d) want 0",
                  tag, bad_data, mem[0], golden[0]);
      end
      $display("run %s done_at=%0d sig=%h", tag, done_at, sig);
   endtask

   task automatic test_back_to_back(input logic [63:0] ref_sig);
      logic [63:0] sig2;
      run_op("second_with_poke", 1'b1, sig2);
      checks++;
      if (sig2 !== ref_sig) begin
         errors++;
         $display("FAIL repeat_sequence got sig=%h want %h", sig2, ref_sig);
      end
   endtask

   task automatic test_reset_mid_op(input logic [63:0] ref_sig);
      int          bad;
      logic [63:0] sig3;
      load_ram();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int rel = 1; rel < 900; rel++) @(negedge clk);
      rst = 1'b1;                    // sampled at the end of c0+900
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({busy, done, ram_we_1, ram_we_2, bf_valid, bf_zeta_idx, ram_addr_1, ram_addr_2} !== 28'd0) begin
         errors++;
         $display("FAIL mid_reset_outputs got busy=%b done=%b we=%b%b v=%b k=%0d a=%0d/%0d want all 0",
                  busy, done, ram_we_1, ram_we_2, bf_valid, bf_zeta_idx, ram_addr_1, ram_addr_2);
      end
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (ram_we_1 !== 1'b0 || ram_we_2 !== 1'b0 || busy !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL mid_reset_no_write got %0d bad cycles want 0", bad);
      end
      run_op("after_reset", 1'b0, sig3);
      checks++;
      if (sig3 !== ref_sig) begin
         errors++;
         $display("FAIL after_reset_sequence got sig=%h want %h", sig3, ref_sig);
      end
   endtask

   // ---------------- main ----------------
   initial begin
      logic [63:0] sig1;
      int          br;
      int          z;
      rst   = 1'b1;
      start = 1'b0;
      for (int k = 0; k < 128; k++) begin
         br = 0;
         for (int bi = 0; bi < 7; bi++) if (((k >> bi) & 1) != 0) br |= (1 << (6 - bi));
         z = 1;
         for (int e = 0; e < br; e++) z = (z * 17) % Q;
         zeta_tab[k] = z;
      end
      for (int i = 0; i < 256; i++) init_poly[i] = (i * 37 + 5) % Q;

      test_reset();
      run_op("first", 1'b0, sig1);
      test_back_to_back(sig1);
      test_reset_mid_op(sig1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
